// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to one shared ALU with a registered response slot.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins).
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] srca0,
    input  logic [WIDTH-1:0] srcb0,
    input  logic [2:0]       alucontrol0,
    input  logic [WIDTH-1:0] srca1,
    input  logic [WIDTH-1:0] srcb1,
    input  logic [2:0]       alucontrol1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             out_owner;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;

    logic [1:0]       grant;
    logic             win;
    logic             slot_free;
    logic             consume;
    logic             accept;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [WIDTH-1:0] alu_result;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 2'b00;
        if (req_valid[0])
            grant = 2'b01;
        else if (req_valid[1])
            grant = 2'b10;
    end
`else
    logic rr_last;

    // rr_last names the most recent winner; the other side wins contention
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_last <= 1'b1;
        else if (accept)
            rr_last <= win;
    end
`endif

    assign win       = grant[1];
    assign consume   = (state == FULL) && rsp_ready[out_owner];
    assign slot_free = (state == EMPTY) || consume;
    assign req_ready = grant & {2{slot_free & reset_n}};
    assign accept    = |req_ready;

    assign a  = win ? srca1 : srca0;
    assign b  = win ? srcb1 : srcb0;
    assign op = win ? alucontrol1 : alucontrol0;

    always_comb begin
        alu_result = '0;
        case (op)
            3'b000:  alu_result = a & b;
            3'b001:  alu_result = a | b;
            3'b010:  alu_result = a + b;
            3'b110:  alu_result = a - b;
            3'b111:  alu_result[0] = (a < b);
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (consume && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Slot payload only moves on acceptance, so backpressure holds it stable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_owner  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b1;
        end else if (accept) begin
            out_owner  <= win;
            out_result <= alu_result;
            out_zero   <= (alu_result == '0);
        end
    end

    assign rsp_valid  = {(state == FULL) & out_owner,
                         (state == FULL) & ~out_owner};
    assign rsp_result = out_result;
    assign rsp_zero   = out_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
`timescale 1ns/1ps
module tb_alu_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] srca0, srcb0, srca1, srcb1;
    logic [2:0]  alucontrol0, alucontrol1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .srca0(srca0),
        .srcb0(srcb0),
        .alucontrol0(alucontrol0),
        .srca1(srca1),
        .srcb1(srcb1),
        .alucontrol1(alucontrol1),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_zero(rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        srca0 = 32'd1; srcb0 = 32'd1; alucontrol0 = 3'b010;
        srca1 = 32'd1; srcb1 = 32'd1; alucontrol1 = 3'b010;
        #12;
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid);
        end
        checks++;
        if (rsp_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result got %h exp 0", rsp_result);
        end
        checks++;
        if (rsp_zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_zero got %b exp 1", rsp_zero);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready got %b exp 00", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 2'b01;
        srca0 = 32'd5; srcb0 = 32'd7; alucontrol0 = 3'b010;
        rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready got %b exp 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp got v=%b r=%h z=%b exp v=01 r=c z=0",
                     rsp_valid, rsp_result, rsp_zero);
        end
        @(negedge clk);
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL single_drain got %b exp 00", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  eg;
        logic [31:0] er;
        @(negedge clk);
        srca0 = 32'd3; srcb0 = 32'd3; alucontrol0 = 3'b110;
        srca1 = 32'd2; srcb1 = 32'd9; alucontrol1 = 3'b111;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            eg = 2'b01;
`else
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            er = (eg == 2'b01) ? 32'd0 : 32'd1;
            #1;
            checks++;
            if (req_ready !== eg) begin
                errors++;
                $display("FAIL rr_grant%0d got %b exp %b", i, req_ready, eg);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== eg || rsp_result !== er || rsp_zero !== (er == 32'd0)) begin
                errors++;
                $display("FAIL rr_rsp%0d got v=%b r=%h z=%b exp v=%b r=%h",
                         i, rsp_valid, rsp_result, rsp_zero, eg, er);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL rr_drain got %b exp 00", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_valid = 2'b10;
        srca1 = 32'hF0; srcb1 = 32'h0F; alucontrol1 = 3'b001;
        rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_accept got %b exp 10", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b01;
        srca0 = 32'd1; srcb0 = 32'd2; alucontrol0 = 3'b010;
        rsp_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_ready%0d got %b exp 00", i, req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 2'b10 || rsp_result !== 32'hFF || rsp_zero !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b r=%h z=%b exp v=10 r=ff z=0",
                         i, rsp_valid, rsp_result, rsp_zero);
            end
        end
        @(negedge clk);
        rsp_ready = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_replace_ready got %b exp 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'd3) begin
            errors++;
            $display("FAIL bp_replace got v=%b r=%h exp v=01 r=3", rsp_valid, rsp_result);
        end
        @(negedge clk);
        rsp_ready = 2'b11;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [2:0]  vo [5];
        logic [31:0] vr [5];
        va[0] = 32'hFFFFFFFF; vb[0] = 32'd1; vo[0] = 3'b010; vr[0] = 32'd0;
        va[1] = 32'd0;        vb[1] = 32'd1; vo[1] = 3'b110; vr[1] = 32'hFFFFFFFF;
        va[2] = 32'hFFFFFFFF; vb[2] = 32'd1; vo[2] = 3'b111; vr[2] = 32'd0;
        va[3] = 32'd5;        vb[3] = 32'd6; vo[3] = 3'b101; vr[3] = 32'd0;
        va[4] = 32'hF0F0;     vb[4] = 32'hFF00; vo[4] = 3'b000; vr[4] = 32'hF000;
        @(negedge clk);
        rsp_ready = 2'b01;
        req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            srca0 = va[i]; srcb0 = vb[i]; alucontrol0 = vo[i];
            #1;
            checks++;
            if (req_ready !== 2'b01) begin
                errors++;
                $display("FAIL wrap_ready%0d got %b exp 01", i, req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 2'b01 || rsp_result !== vr[i] || rsp_zero !== (vr[i] == 32'd0)) begin
                errors++;
                $display("FAIL wrap_vec%0d got r=%h z=%b exp r=%h", i, rsp_result, rsp_zero, vr[i]);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 2'b10;
        srca1 = 32'd1; srcb1 = 32'd1; alucontrol1 = 3'b010;
        rsp_ready = 2'b00;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_result !== 32'd2) begin
            errors++;
            $display("FAIL mid_setup got v=%b r=%h exp v=10 r=2", rsp_valid, rsp_result);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got v=%b r=%h z=%b exp v=00 r=0 z=1",
                     rsp_valid, rsp_result, rsp_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        srca0 = 32'd4; srcb0 = 32'd4; alucontrol0 = 3'b010;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL mid_first_grant got %b exp 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'd8) begin
            errors++;
            $display("FAIL mid_first_rsp got v=%b r=%h exp v=01 r=8", rsp_valid, rsp_result);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end that shares one 32-bit ALU, with the same operation set as the CPU datapath ALU, between independent clients, e.g. the main datapath and a branch/address helper. Each requester issues an operation with a valid/ready handshake. The block arbitrates round-robin, evaluates the winner's operation on the shared ALU, and returns the result and zero flag to the winner through a one-entry registered response slot with valid/ready backpressure. Sustained throughput is one operation per cycle.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: operation of requester i accepted this cycle
- srca0, srcb0  in  WIDTH each  requester 0 operands
- alucontrol0  in  3  requester 0 operation code
- srca1, srcb1  in  WIDTH each  requester 1 operands
- alucontrol1  in  3  requester 1 operation code
- rsp_valid  out  2  bit i: response slot holds a result for requester i
- rsp_ready  in  2  bit i: requester i consumes its response
- rsp_result  out  WIDTH  result in slot (shared by both requesters)
- rsp_zero  out  1  1 when rsp_result == 0

## Operation
- Operation codes:
  - 000 AND
  - 001 OR
  - 010 ADD (mod 2^WIDTH)
  - 110 SUB (mod 2^WIDTH)
  - 111 unsigned set-less-than; result is 1 or 0, zero-extended
  - 011/100/101 produce result 0, zero=1, with no error indication
- Response slot state machine: EMPTY, FULL (tracks out_valid and out_owner).
- slot_free = EMPTY, or (FULL and rsp_ready[out_owner]).
- Grant, combinational:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not named by rr_last wins.
  - req_ready[i] = grant[i] & slot_free. req_ready never has both bits set.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Acceptance (req_valid[i] & req_ready[i]): the ALU result and zero flag are latched into the slot, out_owner=i, state becomes FULL, rr_last=i.
- Transitions:
  - EMPTY + accept -> FULL
  - FULL + consume + accept -> FULL, new owner and data in the same edge
  - FULL + consume, no accept -> EMPTY
  - FULL + no consume -> FULL, slot held stable
- rsp_valid[i] = FULL & (out_owner == i). The rsp_valid bit of the non-owner is 0.
- rsp_ready of the non-owner is ignored.
- A requester whose req_valid is high but not granted holds its operands. The block places no other stability requirement on unaccepted inputs.

## Timing
- Reset asserted, asynchronous and immediate:
  - state EMPTY, so rsp_valid=00
  - rsp_result=0, rsp_zero=1
  - rr_last=1, so requester 0 wins the first contention
  - A held response is discarded.
  - req_ready is 00 while reset_n is low.
- Latency: accepted at edge N, rsp_valid is high after edge N, visible in cycle N+1.
- Throughput: one accept per cycle when the owner consumes every cycle (pipelined replace).
- Backpressure: when FULL and the owner's rsp_ready=0, req_ready=00, and rsp_result/rsp_zero/rsp_valid are held unchanged.
- Fairness: under continuous contention with no backpressure, grants alternate 0,1,0,1…
- rr_last changes only on acceptance.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: requester 0 always wins contention (fixed priority). rr_last is not implemented.
  - Undefined (default): round-robin as specified above.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then requester 0 only: ADD 5+7 accepted -> next cycle rsp_valid=01, rsp_result=12, rsp_zero=0. rsp_ready[0]=1 -> slot EMPTY.
- Both valid every cycle, rsp_ready=11:
  - req0 SUB 3-3, req1 SLT 2<9
  - Grants alternate 0,1,0,1, starting with 0. Results 0 (zero=1) and 1 alternate with rsp_valid 01/10.
  - With ALU_ARB_FIXED_PRIO_EN: requester 0 only.
- Backpressure:
  - req1 OR 0xF0|0x0F accepted, rsp_ready[1]=0 for 3 cycles -> result 0xFF held, req_ready=00 throughout.
  - rsp_ready[0]=1 in that window has no effect.
  - rsp_ready[1]=1 with req0 pending -> req0 accepted in the same cycle.
- Wrap and unsigned compare:
  - ADD 0xFFFFFFFF+1 -> 0, zero=1.
  - SUB 0-1 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF<1 -> 0.
  - Code 101 -> 0, zero=1.
- Reset mid-operation: slot FULL, owner 1, reset_n low mid-cycle -> rsp_valid=00 immediately, rsp_result=0. After release, simultaneous requests -> requester 0 granted first.
